// File: rtl/instruction_decoder.sv
// Instruction queue plus RV32I decoder feeding the dec_* issue bus.
// Fetched words are buffered in a DEPTH-entry FIFO. The head entry is decoded
// combinationally and captured into a valid/stall output register.

`ifndef INSTRUCTION_DECODER_DEFS
`define INSTRUCTION_DECODER_DEFS
`define XLEN            32
`define INST_TYPE_WIDTH 6
`define REG_CNT_WIDTH   5
`define LUI    6'd0
`define AUIPC  6'd1
`define JAL    6'd2
`define JALR   6'd3
`define BEQ    6'd4
`define BNE    6'd5
`define BLT    6'd6
`define BGE    6'd7
`define BLTU   6'd8
`define BGEU   6'd9
`define LB     6'd10
`define LH     6'd11
`define LW     6'd12
`define LBU    6'd13
`define LHU    6'd14
`define SB     6'd15
`define SH     6'd16
`define SW     6'd17
`define ADDI   6'd18
`define SLTI   6'd19
`define SLTIU  6'd20
`define XORI   6'd21
`define ORI    6'd22
`define ANDI   6'd23
`define SLLI   6'd24
`define SRLI   6'd25
`define SRAI   6'd26
`define ADD    6'd27
`define SUB    6'd28
`define SLL    6'd29
`define SLT    6'd30
`define SLTU   6'd31
`define XOR    6'd32
`define SRL    6'd33
`define SRA    6'd34
`define OR     6'd35
`define AND    6'd36
`endif

module instruction_decoder #(
  parameter int DEPTH       = 8,
  parameter int DEPTH_WIDTH = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        stall,
  input  logic                        if_ready,
  input  logic [31:0]                 if_inst,
  input  logic [`XLEN-1:0]            if_pc,
  input  logic                        if_jump_pred,
  output logic                        iq_full,
  output logic                        dec_ready,
  output logic [`INST_TYPE_WIDTH-1:0] dec_op,
  output logic                        dec_jump_pred,
  output logic [`REG_CNT_WIDTH-1:0]   dec_rd,
  output logic [`REG_CNT_WIDTH-1:0]   dec_rs1,
  output logic [`REG_CNT_WIDTH-1:0]   dec_rs2,
  output logic [`XLEN-1:0]            dec_imm,
  output logic [`XLEN-1:0]            dec_pc
);

  localparam logic [DEPTH_WIDTH:0] FULL_CNT = (DEPTH_WIDTH + 1)'(DEPTH);
  localparam logic [DEPTH_WIDTH:0] ONE_CNT  = (DEPTH_WIDTH + 1)'(1);

  logic [31:0]            mem_inst [DEPTH];
  logic [`XLEN-1:0]       mem_pc   [DEPTH];
  logic                   mem_jp   [DEPTH];
  logic [DEPTH_WIDTH-1:0] head, tail;
  logic [DEPTH_WIDTH:0]   count;

  logic advance, push, pop;
  logic [31:0] h_inst;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd_f, rs1_f, rs2_f;
  logic [`XLEN-1:0] imm_i, imm_sh, imm_s, imm_b, imm_u, imm_j;

  logic [`INST_TYPE_WIDTH-1:0] d_op;
  logic [`REG_CNT_WIDTH-1:0]   d_rd, d_rs1, d_rs2;
  logic [`XLEN-1:0]            d_imm;
  logic                        legal;

  assign iq_full = (count == FULL_CNT);
  assign advance = !dec_ready || !stall;
  // Full blocks the push even when a pop happens in the same cycle.
  assign push    = if_ready && !iq_full && !flush;
  assign pop     = advance && (count != '0) && !flush;

  assign h_inst = mem_inst[head];
  assign opc    = h_inst[6:0];
  assign f3     = h_inst[14:12];
  assign f7     = h_inst[31:25];
  assign rd_f   = h_inst[11:7];
  assign rs1_f  = h_inst[19:15];
  assign rs2_f  = h_inst[24:20];
  assign imm_i  = {{20{h_inst[31]}}, h_inst[31:20]};
  assign imm_sh = {27'b0, h_inst[24:20]};
  assign imm_s  = {{20{h_inst[31]}}, h_inst[31:25], h_inst[11:7]};
  assign imm_b  = {{19{h_inst[31]}}, h_inst[31], h_inst[7], h_inst[30:25], h_inst[11:8], 1'b0};
  assign imm_u  = {h_inst[31:12], 12'b0};
  assign imm_j  = {{11{h_inst[31]}}, h_inst[31], h_inst[19:12], h_inst[20], h_inst[30:21], 1'b0};

  // FIFO storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[tail] <= if_inst;
      mem_pc[tail]   <= if_pc;
      mem_jp[tail]   <= if_jump_pred;
    end
  end

  // FIFO pointers and occupancy; flush empties the queue in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      count <= count + ONE_CNT;
      else if (!push && pop) count <= count - ONE_CNT;
    end
  end

  // RV32I decode of the head entry; anything unrecognised becomes a NOP.
  always_comb begin
    d_op  = `ADDI;
    d_rd  = '0;
    d_rs1 = '0;
    d_rs2 = '0;
    d_imm = '0;
    legal = 1'b1;
    case (opc)
      7'b0110111: begin d_op = `LUI;   d_rd = rd_f; d_imm = imm_u; end
      7'b0010111: begin d_op = `AUIPC; d_rd = rd_f; d_imm = imm_u; end
      7'b1101111: begin d_op = `JAL;   d_rd = rd_f; d_imm = imm_j; end
      7'b1100111: begin
        d_op = `JALR; d_rd = rd_f; d_rs1 = rs1_f; d_imm = imm_i;
        legal = (f3 == 3'b000);
      end
      7'b1100011: begin
        d_rs1 = rs1_f; d_rs2 = rs2_f; d_imm = imm_b;
        case (f3)
          3'b000:  d_op = `BEQ;
          3'b001:  d_op = `BNE;
          3'b100:  d_op = `BLT;
          3'b101:  d_op = `BGE;
          3'b110:  d_op = `BLTU;
          3'b111:  d_op = `BGEU;
          default: legal = 1'b0;
        endcase
      end
      7'b0000011: begin
        d_rd = rd_f; d_rs1 = rs1_f; d_imm = imm_i;
        case (f3)
          3'b000:  d_op = `LB;
          3'b001:  d_op = `LH;
          3'b010:  d_op = `LW;
          3'b100:  d_op = `LBU;
          3'b101:  d_op = `LHU;
          default: legal = 1'b0;
        endcase
      end
      7'b0100011: begin
        d_rs1 = rs1_f; d_rs2 = rs2_f; d_imm = imm_s;
        case (f3)
          3'b000:  d_op = `SB;
          3'b001:  d_op = `SH;
          3'b010:  d_op = `SW;
          default: legal = 1'b0;
        endcase
      end
      7'b0010011: begin
        d_rd = rd_f; d_rs1 = rs1_f; d_imm = imm_i;
        case (f3)
          3'b000: d_op = `ADDI;
          3'b010: d_op = `SLTI;
          3'b011: d_op = `SLTIU;
          3'b100: d_op = `XORI;
          3'b110: d_op = `ORI;
          3'b111: d_op = `ANDI;
          3'b001: begin d_op = `SLLI; d_imm = imm_sh; legal = (f7 == 7'b0000000); end
          default: begin
            d_imm = imm_sh;
            if (f7 == 7'b0000000)      d_op = `SRLI;
            else if (f7 == 7'b0100000) d_op = `SRAI;
            else                       legal = 1'b0;
          end
        endcase
      end
      7'b0110011: begin
        d_rd = rd_f; d_rs1 = rs1_f; d_rs2 = rs2_f;
        if (f7 == 7'b0100000) begin
          if (f3 == 3'b000)      d_op = `SUB;
          else if (f3 == 3'b101) d_op = `SRA;
          else                   legal = 1'b0;
        end else if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  d_op = `ADD;
            3'b001:  d_op = `SLL;
            3'b010:  d_op = `SLT;
            3'b011:  d_op = `SLTU;
            3'b100:  d_op = `XOR;
            3'b101:  d_op = `SRL;
            3'b110:  d_op = `OR;
            default: d_op = `AND;
          endcase
        end else begin
          legal = 1'b0;
        end
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      d_op  = `ADDI;
      d_rd  = '0;
      d_rs1 = '0;
      d_rs2 = '0;
      d_imm = '0;
    end
  end

  // Output pipeline register: loads the decoded head when free or not stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_ready     <= 1'b0;
      dec_op        <= '0;
      dec_jump_pred <= 1'b0;
      dec_rd        <= '0;
      dec_rs1       <= '0;
      dec_rs2       <= '0;
      dec_imm       <= '0;
      dec_pc        <= '0;
    end else if (flush) begin
      dec_ready <= 1'b0;
    end else if (advance) begin
      if (count != '0) begin
        dec_ready     <= 1'b1;
        dec_op        <= d_op;
        dec_jump_pred <= mem_jp[head];
        dec_rd        <= d_rd;
        dec_rs1       <= d_rs1;
        dec_rs2       <= d_rs2;
        dec_imm       <= d_imm;
        dec_pc        <= mem_pc[head];
      end else begin
        dec_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_decoder.sv
// Scoreboard bench for instruction_decoder: accepted pushes enqueue the
// hand-computed decode; a monitor pops and compares on each consumed output.
module tb_instruction_decoder;

  localparam logic [5:0] OP_LUI = 6'd0, OP_AUIPC = 6'd1, OP_JAL = 6'd2, OP_BEQ = 6'd4,
                         OP_BNE = 6'd5, OP_LW = 6'd12, OP_SW = 6'd17, OP_ADDI = 6'd18,
                         OP_SRAI = 6'd26, OP_SUB = 6'd28;

  typedef struct {
    logic [31:0] inst;
    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
  } vec_t;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        jp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, stall, if_ready, if_jump_pred;
  logic [31:0] if_inst, if_pc;
  logic        iq_full, dec_ready, dec_jump_pred;
  logic [5:0]  dec_op;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic [31:0] dec_imm, dec_pc;

  vec_t vec [12];
  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;
  int   n_seen = 0;
  bit   rdone  = 1'b0;

  instruction_decoder #(.DEPTH(8), .DEPTH_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc), .if_jump_pred(if_jump_pred),
    .iq_full(iq_full), .dec_ready(dec_ready), .dec_op(dec_op), .dec_jump_pred(dec_jump_pred),
    .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_imm(dec_imm), .dec_pc(dec_pc)
  );

  always #5 clk = ~clk;

  // Monitor: every output consumed by downstream must match the queue head.
  always @(negedge clk) begin
    if (rst_n && dec_ready && !stall && !flush) begin
      exp_t got, e;
      got = '{op: dec_op, rd: dec_rd, rs1: dec_rs1, rs2: dec_rs2,
              imm: dec_imm, pc: dec_pc, jp: dec_jump_pred};
      checks++;
      n_seen++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got pc=%h op=%0d, none expected", dec_pc, dec_op);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL decode pc=%h got op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h jp=%b pc=%h want op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h jp=%b pc=%h",
                   e.pc, got.op, got.rd, got.rs1, got.rs2, got.imm, got.jp, got.pc,
                   e.op, e.rd, e.rs1, e.rs2, e.imm, e.jp, e.pc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Offer one vector until accepted; the expected decode is queued on acceptance.
  task automatic push(input int v, input logic [31:0] pc, input logic jp);
    exp_t e;
    bit   done = 1'b0;
    e = '{op: vec[v].op, rd: vec[v].rd, rs1: vec[v].rs1, rs2: vec[v].rs2,
          imm: vec[v].imm, pc: pc, jp: jp};
    if_ready = 1'b1; if_inst = vec[v].inst; if_pc = pc; if_jump_pred = jp;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (!iq_full && !flush) begin
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if_ready = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL push_timeout pc=%h not accepted, want accepted", pc);
    end
  endtask

  // Push into an idle block and check the two-edge latency and one-cycle presence.
  task automatic push_timed(input int v, input logic [31:0] pc, input logic jp);
    push(v, pc, jp);
    check("no_bypass_ready", 64'(dec_ready), 64'd0);
    @(posedge clk); #1;
    check("latency_ready", 64'(dec_ready), 64'd1);
    @(posedge clk); #1;
    check("ready_clears", 64'(dec_ready), 64'd0);
  endtask

  task automatic wait_drain(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !dec_ready) ok = 1'b1;
    end
    @(posedge clk); #1;
    check(name, 64'(ok), 64'd1);
  endtask

  initial begin
    logic [31:0] snap_imm, snap_pc;
    logic [20:0] snap_f;
    int seen0;

    vec[0]  = '{32'hFFB10093, OP_ADDI,  5'd1, 5'd2, 5'd0, 32'hFFFFFFFB};
    vec[1]  = '{32'h00208463, OP_BEQ,   5'd0, 5'd1, 5'd2, 32'h00000008};
    vec[2]  = '{32'h123452B7, OP_LUI,   5'd5, 5'd0, 5'd0, 32'h12345000};
    vec[3]  = '{32'h40725193, OP_SRAI,  5'd3, 5'd4, 5'd0, 32'h00000007};
    vec[4]  = '{32'hFFFFFFFF, OP_ADDI,  5'd0, 5'd0, 5'd0, 32'h00000000};
    vec[5]  = '{32'h402081B3, OP_SUB,   5'd3, 5'd1, 5'd2, 32'h00000000};
    vec[6]  = '{32'h0020A423, OP_SW,    5'd0, 5'd1, 5'd2, 32'h00000008};
    vec[7]  = '{32'hFFDFF0EF, OP_JAL,   5'd1, 5'd0, 5'd0, 32'hFFFFFFFC};
    vec[8]  = '{32'hFFF32283, OP_LW,    5'd5, 5'd6, 5'd0, 32'hFFFFFFFF};
    vec[9]  = '{32'hFFFFF397, OP_AUIPC, 5'd7, 5'd0, 5'd0, 32'hFFFFF000};
    vec[10] = '{32'hFE4198E3, OP_BNE,   5'd0, 5'd3, 5'd4, 32'hFFFFFFF0};
    vec[11] = '{32'h40209033, OP_ADDI,  5'd0, 5'd0, 5'd0, 32'h00000000};

    rst_n = 1'b0; flush = 1'b0; stall = 1'b0; if_ready = 1'b0;
    if_inst = '0; if_pc = '0; if_jump_pred = 1'b0;
    #2;
    check("reset_outputs", {dec_ready, dec_op, dec_jump_pred, dec_rd, dec_rs1, dec_rs2, iq_full}, 64'd0);
    check("reset_imm_pc", {dec_imm, dec_pc}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Single ADDI with latency, then B/U/shift and the rest of the table.
    push_timed(0, 32'h0000_0100, 1'b0);
    push(1, 32'h0000_0104, 1'b1);
    push(2, 32'h0000_0108, 1'b0);
    push(3, 32'h0000_010C, 1'b0);
    for (int i = 4; i < 12; i++) push(i, 32'h0000_0200 + 32'(4 * i), i[0]);
    wait_drain("drain_table");

    // Stall hold: outputs must stay frozen, then drain in order.
    stall = 1'b1;
    push(5, 32'h0000_0400, 1'b0);
    push(6, 32'h0000_0404, 1'b1);
    push(7, 32'h0000_0408, 1'b0);
    check("stall_ready", 64'(dec_ready), 64'd1);
    snap_imm = dec_imm; snap_pc = dec_pc;
    snap_f = {dec_op, dec_rd, dec_rs1, dec_rs2};
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("stall_hold_fields", {11'd0, dec_ready, dec_jump_pred, snap_f, dec_op, dec_rd, dec_rs1, dec_rs2},
            {11'd0, 1'b1, 1'b0, snap_f, snap_f});
      check("stall_hold_imm_pc", {dec_imm, dec_pc}, {snap_imm, snap_pc});
    end
    stall = 1'b0;
    wait_drain("drain_stall");

    // Full: one held in output, eight in FIFO, the tenth refused until a pop.
    stall = 1'b1;
    for (int i = 0; i < 9; i++) push(i, 32'h0000_0300 + 32'(4 * i), 1'b0);
    check("full_after_9", 64'(iq_full), 64'd1);
    if_ready = 1'b1; if_inst = vec[9].inst; if_pc = 32'h0000_0324; if_jump_pred = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("full_refuses", 64'(iq_full), 64'd1);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    push(9, 32'h0000_0324, 1'b1);
    wait_drain("drain_full");

    // Twenty instructions with random stall; wraps the pointers.
    seen0 = n_seen;
    fork
      begin
        for (int i = 0; i < 20; i++) push(i % 12, 32'h0000_1000 + 32'(4 * i), i[1]);
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk); #1;
          stall = 1'($urandom_range(0, 1));
        end
      end
    join
    stall = 1'b0;
    wait_drain("drain_random");
    check("random_count", 64'(n_seen - seen0), 64'd20);

    // Flush with five queued and a valid output; concurrent offer is dropped.
    stall = 1'b1;
    for (int i = 0; i < 6; i++) push(i, 32'h0000_0500 + 32'(4 * i), 1'b0);
    check("pre_flush_ready", 64'(dec_ready), 64'd1);
    flush = 1'b1; if_ready = 1'b1; if_inst = vec[2].inst; if_pc = 32'h0000_0DEA; if_jump_pred = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; if_ready = 1'b0; stall = 1'b0;
    sb.delete();
    check("flush_ready", 64'(dec_ready), 64'd0);
    check("flush_full", 64'(iq_full), 64'd0);
    push_timed(3, 32'h0000_0600, 1'b1);
    wait_drain("drain_flush");

    // Asynchronous reset mid-stream, then an illegal opcode decodes as NOP.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) push(7 + i, 32'h0000_0700 + 32'(4 * i), 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {dec_ready, dec_op, dec_jump_pred, dec_rd, dec_rs1, dec_rs2, iq_full}, 64'd0);
    check("async_reset_imm_pc", {dec_imm, dec_pc}, 64'd0);
    sb.delete();
    stall = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    push_timed(4, 32'h0000_2000, 1'b1);
    wait_drain("drain_illegal");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout sim time exceeded, want completion");
    $fatal(1, "timeout");
  end

endmodule
